fft_spectrum_buffer: RTL and testbench

Downstream consumer of the FFT core output stream (dv, xk_index, magnitude). Captures one complete unload frame into a ping-pong bin RAM and tracks the peak non-DC bin. Presents a stable, fully committed spectrum to the VGA plotting logic through a registered random-access read port. The write bank and display bank swap only on frame completion, so the display never shows a partial frame.

---
 rtl/fft_spectrum_buffer.sv | 152 +++++++++++++++
 tb/tb_fft_spectrum_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_buffer.sv
// Ping-pong spectrum buffer on the FFT unload stream. It captures one frame,
// tracks the largest non-DC bin, and shows only the last fully committed frame.
module fft_spectrum_buffer #(
   parameter int FFT_N      = 1024,
   parameter int IDX_W      = 10,
   parameter int MAG_W      = 10,
   parameter int STORE_BINS = 512,
   parameter int ADDR_W     = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fft_data_valid,
   input  logic [IDX_W-1:0]  fft_out_index,
   input  logic [MAG_W-1:0]  fft_out_abs,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [MAG_W-1:0]  rd_data,
   output logic              display_valid,
   output logic              frame_ready,
   output logic [ADDR_W-1:0] peak_index,
   output logic [MAG_W-1:0]  peak_abs,
   output logic [7:0]        frame_count,
   output logic              seq_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, COMMIT = 2'd2} state_t;

   localparam logic [IDX_W:0]   STORE_LIM = (IDX_W + 1)'(STORE_BINS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FFT_N - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  expected_q, expected_d;
   logic [ADDR_W-1:0] rp_idx_q, rp_idx_d;
   logic [MAG_W-1:0]  rp_abs_q, rp_abs_d;
   logic              seq_err_q, seq_err_d;
   logic              wr_bank_q;
   logic              display_valid_q;
   logic              frame_ready_q;
   logic [ADDR_W-1:0] peak_index_q;
   logic [MAG_W-1:0]  peak_abs_q;
   logic [MAG_W-1:0]  rd_data_q;
   logic [7:0]        frame_count_q;
   logic              wr_en_s, commit_s, in_store_s;

   // Both banks live in one array; the bank bit is the address MSB.
   logic [MAG_W-1:0]  mem_q [0:2*STORE_BINS-1];

   // Frame sequencing: write enable, running peak, commit and error detection.
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      rp_idx_d   = rp_idx_q;
      rp_abs_d   = rp_abs_q;
      seq_err_d  = 1'b0;
      wr_en_s    = 1'b0;
      commit_s   = 1'b0;
      in_store_s = ({1'b0, fft_out_index} < STORE_LIM);
      case (state_q)
         IDLE, COMMIT: begin
            if (fft_data_valid && (fft_out_index == '0)) begin
               state_d    = CAPTURE;
               expected_d = IDX_W'(1);
               rp_idx_d   = '0;
               rp_abs_d   = '0;
               wr_en_s    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            if (!fft_data_valid) begin
               state_d = CAPTURE;
            end else if (fft_out_index == expected_q) begin
               wr_en_s    = in_store_s;
               expected_d = expected_q + IDX_W'(1);
               // DC is excluded; strict compare keeps the lowest index on ties.
               if (in_store_s && (fft_out_index != '0) && (fft_out_abs > rp_abs_q)) begin
                  rp_idx_d = fft_out_index[ADDR_W-1:0];
                  rp_abs_d = fft_out_abs;
               end else begin
                  rp_idx_d = rp_idx_q;
                  rp_abs_d = rp_abs_q;
               end
               if (fft_out_index == LAST_IDX) begin
                  state_d  = COMMIT;
                  commit_s = 1'b1;
               end else begin
                  state_d = CAPTURE;
               end
            end else if (fft_out_index == '0) begin
               seq_err_d  = 1'b1;
               state_d    = CAPTURE;
               expected_d = IDX_W'(1);
               rp_idx_d   = '0;
               rp_abs_d   = '0;
               wr_en_s    = 1'b1;
            end else begin
               seq_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; the swap and peak publish on the edge accepting the last index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         expected_q      <= '0;
         rp_idx_q        <= '0;
         rp_abs_q        <= '0;
         seq_err_q       <= 1'b0;
         wr_bank_q       <= 1'b0;
         display_valid_q <= 1'b0;
         frame_ready_q   <= 1'b0;
         peak_index_q    <= '0;
         peak_abs_q      <= '0;
         frame_count_q   <= 8'd0;
         rd_data_q       <= '0;
      end else begin
         state_q       <= state_d;
         expected_q    <= expected_d;
         rp_idx_q      <= rp_idx_d;
         rp_abs_q      <= rp_abs_d;
         seq_err_q     <= seq_err_d;
         frame_ready_q <= commit_s;
         if (commit_s) begin
            wr_bank_q       <= ~wr_bank_q;
            peak_index_q    <= rp_idx_d;
            peak_abs_q      <= rp_abs_d;
            frame_count_q   <= frame_count_q + 8'd1;
            display_valid_q <= 1'b1;
         end
         rd_data_q <= display_valid_q ? mem_q[{~wr_bank_q, rd_addr}] : '0;
      end
   end

   // Bin RAM write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[{wr_bank_q, fft_out_index[ADDR_W-1:0]}] <= fft_out_abs;
      end
   end

   assign rd_data       = rd_data_q;
   assign display_valid = display_valid_q;
   assign frame_ready   = frame_ready_q;
   assign peak_index    = peak_index_q;
   assign peak_abs      = peak_abs_q;
   assign frame_count   = frame_count_q;
   assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Scoreboard bench for fft_spectrum_buffer: stimulus pushes expected commits,
// sequence errors and reads into queues; a negedge monitor pops and compares.
module tb_fft_spectrum_buffer;
   logic       clk = 1'b0;
   logic       reset;
   logic       fft_data_valid;
   logic [9:0] fft_out_index;
   logic [9:0] fft_out_abs;
   logic [8:0] rd_addr;
   logic [9:0] rd_data;
   logic       display_valid;
   logic       frame_ready;
   logic [8:0] peak_index;
   logic [9:0] peak_abs;
   logic [7:0] frame_count;
   logic       seq_err;

   always #5 clk = ~clk;

   fft_spectrum_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .fft_data_valid (fft_data_valid),
      .fft_out_index  (fft_out_index),
      .fft_out_abs    (fft_out_abs),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .display_valid  (display_valid),
      .frame_ready    (frame_ready),
      .peak_index     (peak_index),
      .peak_abs       (peak_abs),
      .frame_count    (frame_count),
      .seq_err        (seq_err)
   );

   typedef struct { int cyc; int fc; int pi; int pa; } commit_t;
   typedef struct { int cyc; int val; } rd_t;

   commit_t cq[$];
   rd_t     rq[$];
   int      sq[$];
   int      checks   = 0;
   int      failures = 0;
   int      cyc      = 0;
   logic    track5   = 1'b0;
   int      disp5    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, want, $time);
      end
   endfunction

   // Monitor: pops an expectation whenever the DUT presents a pulse or a read result.
   always @(negedge clk) begin
      commit_t ce;
      rd_t     re;
      int      sc;
      if (frame_ready) begin
         if (cq.size() == 0) begin
            chk("frame_ready_unexpected", 1, 0);
         end else begin
            ce = cq.pop_front();
            chk("frame_ready_cycle", cyc, ce.cyc);
            chk("frame_count", int'(frame_count), ce.fc);
            chk("peak_index", int'(peak_index), ce.pi);
            chk("peak_abs", int'(peak_abs), ce.pa);
            chk("display_valid", int'(display_valid), 1);
         end
      end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
         ce = cq.pop_front();
         chk("frame_ready_missing", 0, 1);
      end
      if (seq_err) begin
         if (sq.size() == 0) begin
            chk("seq_err_unexpected", 1, 0);
         end else begin
            sc = sq.pop_front();
            chk("seq_err_cycle", cyc, sc);
         end
      end else if (sq.size() > 0 && sq[0] <= cyc) begin
         sc = sq.pop_front();
         chk("seq_err_missing", 0, 1);
      end
      while (rq.size() > 0 && rq[0].cyc <= cyc) begin
         re = rq.pop_front();
         if (re.cyc == cyc) chk("rd_data", int'(rd_data), re.val);
         else chk("rd_data_unchecked", 0, 1);
      end
   end

   function automatic int absf(input int kind, input int i);
      case (kind)
         0: return i ^ 'h155;
         1: return (i == 0 || i == 600) ? 1023 : ((i == 37 || i == 200) ? 900 : 10);
         2: return 1023 - i;
         3: return i & 255;
         4: return i ^ 'h2AA;
         5: return (i == 9) ? 77 : 3;
         6: return (i == 511) ? 21 : 20;
         default: return 0;
      endcase
   endfunction

   task automatic push_seq();
      sq.push_back(cyc);
   endtask

   task automatic push_commit(input int fc, input int pi, input int pa);
      commit_t c;
      c.cyc = cyc; c.fc = fc; c.pi = pi; c.pa = pa;
      cq.push_back(c);
   endtask

   task automatic step(input logic v, input int idx, input int a);
      rd_t r;
      fft_data_valid = v;
      fft_out_index  = idx[9:0];
      fft_out_abs    = a[9:0];
      @(posedge clk);
      #1;
      if (track5) begin
         r.cyc = cyc; r.val = disp5;
         rq.push_back(r);
      end
      fft_data_valid = 1'b0;
   endtask

   task automatic send_frame(input int kind, input bit gaps, input bit restart,
                             input int fc, input int pi, input int pa);
      for (int i = 0; i < 1024; i++) begin
         if (gaps && (i % 7 == 3)) step(1'b0, i, 0);
         step(1'b1, i, absf(kind, i));
         if (restart && i == 0) push_seq();
      end
      push_commit(fc, pi, pa);
      if (track5) disp5 = absf(kind, 5);
   endtask

   task automatic rd(input int addr, input int want);
      rd_t r;
      rd_addr = addr[8:0];
      @(posedge clk);
      #1;
      r.cyc = cyc; r.val = want;
      rq.push_back(r);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_data"}, int'(rd_data), 0);
      chk({tag, "_display_valid"}, int'(display_valid), 0);
      chk({tag, "_frame_ready"}, int'(frame_ready), 0);
      chk({tag, "_peak_index"}, int'(peak_index), 0);
      chk({tag, "_peak_abs"}, int'(peak_abs), 0);
      chk({tag, "_frame_count"}, int'(frame_count), 0);
      chk({tag, "_seq_err"}, int'(seq_err), 0);
   endtask

   initial begin
      reset          = 1'b1;
      fft_data_valid = 1'b0;
      fft_out_index  = 10'd0;
      fft_out_abs    = 10'd0;
      rd_addr        = 9'd0;
      #3 reset = 1'b0;
      #1 chk_zero("por");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      rd(3, 0);

      // Full frame: peak of i^0x155 over bins 1..511 is 511 at bin 170
      send_frame(0, 1'b0, 1'b0, 1, 170, 511);
      for (int a = 0; a < 512; a++) rd(a, a ^ 'h155);

      // DC excluded, tie keeps lower bin, bins >= 512 neither stored nor peak
      send_frame(1, 1'b0, 1'b0, 2, 37, 900);
      rd(0, 1023); rd(37, 900); rd(200, 900); rd(1, 10); rd(88, 10); rd(511, 10);

      // Sequence break discards the frame; display keeps the previous one
      for (int i = 0; i < 100; i++) step(1'b1, i, 5);
      step(1'b1, 150, 5);
      push_seq();
      rd(37, 900); rd(0, 1023); rd(50, 10);
      send_frame(2, 1'b0, 1'b0, 3, 1, 1022);
      rd(1, 1022); rd(511, 512); rd(37, 986);

      // Restart at a second index 0 clears the running peak
      for (int i = 0; i < 500; i++) step(1'b1, i, 1000);
      send_frame(3, 1'b0, 1'b1, 4, 255, 255);
      rd(499, 243); rd(256, 0); rd(300, 44); rd(5, 5);

      // Ping-pong isolation on bin 5, next frame starts in the commit cycle
      disp5  = 5;
      track5 = 1'b1;
      send_frame(4, 1'b0, 1'b0, 5, 341, 1023);
      send_frame(5, 1'b0, 1'b0, 6, 9, 77);
      track5 = 1'b0;
      rd(5, 3); rd(9, 77); rd(0, 3);

      // Asynchronous reset in the middle of a capture
      for (int i = 0; i <= 300; i++) step(1'b1, i, 50);
      #2 reset = 1'b0;
      #1 chk_zero("async");
      @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 301, 50);
      rd(5, 0); rd(9, 0);
      send_frame(6, 1'b1, 1'b0, 1, 511, 21);
      rd(511, 21); rd(0, 20); rd(510, 20);

      repeat (4) @(posedge clk);
      #1;
      chk("commit_queue_drained", cq.size(), 0);
      chk("seq_queue_drained", sq.size(), 0);
      chk("read_queue_drained", rq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
